// File: rtl/vga_timing_scheduler.sv
// VGA 25 MHz timing generator: H/V counters, sync/blank decode, and a
// per-line prefetch request scheduler with a sticky underrun flag.
module vga_timing_scheduler #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk_25MHz,
  input  logic        reset_n,
  input  logic        enable,
  output logic [15:0] H_count_value,
  output logic [15:0] V_count_value,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic        line_req,
  output logic [15:0] line_req_num,
  input  logic        line_ack,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] H_LAST_C   = 16'(H_TOTAL - 1);
  localparam logic [15:0] H_VIS_C    = 16'(H_VISIBLE);
  localparam logic [15:0] HS_START_C = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END_C   = 16'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [15:0] V_LAST_C   = 16'(V_TOTAL - 1);
  localparam logic [15:0] V_VIS_C    = 16'(V_VISIBLE);
  localparam logic [15:0] VS_START_C = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END_C   = 16'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  typedef enum logic [0:0] {
    IDLE_S = 1'b0,
    REQ_S  = 1'b1
  } state_t;

  logic [15:0] h_r;
  logic [15:0] v_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        video_on_r;
  logic        frame_start_r;
  logic        line_req_r;
  logic [15:0] line_req_num_r;
  logic        underrun_r;
  state_t      state_r;

  logic [15:0] h_next_s;
  logic [15:0] v_next_s;
  logic        h_wrap_s;
  logic        hsync_next_s;
  logic        vsync_next_s;
  logic        video_on_next_s;
  logic        frame_start_next_s;
  logic        next_line_valid_s;
  logic [15:0] next_line_s;
  logic        issue_s;
  logic        miss_s;
  state_t      state_next_s;
  logic        line_req_next_s;
  logic [15:0] line_req_num_next_s;
  logic        underrun_next_s;

  // Counter advance; h_wrap_s marks an advancing edge that moves H to 0.
  always_comb begin
    h_next_s = h_r;
    v_next_s = v_r;
    h_wrap_s = 1'b0;
    if (enable) begin
      if (h_r == H_LAST_C) begin
        h_next_s = 16'd0;
        h_wrap_s = 1'b1;
        if (v_r == V_LAST_C) begin
          v_next_s = 16'd0;
        end else begin
          v_next_s = v_r + 16'd1;
        end
      end else begin
        h_next_s = h_r + 16'd1;
      end
    end else begin
      h_next_s = h_r;
      v_next_s = v_r;
    end
  end

  // Decode from the next counter values so outputs line up with the counters.
  always_comb begin
    hsync_next_s       = hsync_r;
    vsync_next_s       = vsync_r;
    video_on_next_s    = video_on_r;
    frame_start_next_s = 1'b0;
    if (enable) begin
      hsync_next_s = ((h_next_s >= HS_START_C) && (h_next_s <= HS_END_C)) ?
                     SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_next_s = ((v_next_s >= VS_START_C) && (v_next_s <= VS_END_C)) ?
                     SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_next_s    = (h_next_s < H_VIS_C) && (v_next_s < V_VIS_C);
      frame_start_next_s = (h_next_s == 16'd0) && (v_next_s == 16'd0);
    end else begin
      hsync_next_s       = hsync_r;
      vsync_next_s       = vsync_r;
      video_on_next_s    = video_on_r;
      frame_start_next_s = 1'b0;
    end
  end

  // Which line the reader must fetch during the current line's blanking.
  always_comb begin
    next_line_valid_s = 1'b0;
    next_line_s       = 16'd0;
    if (v_r == V_LAST_C) begin
      next_line_valid_s = 1'b1;
      next_line_s       = 16'd0;
    end else if ((v_r + 16'd1) < V_VIS_C) begin
      next_line_valid_s = 1'b1;
      next_line_s       = v_r + 16'd1;
    end else begin
      next_line_valid_s = 1'b0;
      next_line_s       = 16'd0;
    end
  end

  assign issue_s = enable && (h_r == H_VIS_C) && next_line_valid_s;
  assign miss_s  = (state_r == REQ_S) && !line_ack && h_wrap_s;

  // Prefetch FSM next state; an ack on the deadline edge still counts as served.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE_S: begin
        if (issue_s) begin
          state_next_s = REQ_S;
        end else begin
          state_next_s = IDLE_S;
        end
      end
      REQ_S: begin
        if (line_ack || h_wrap_s) begin
          state_next_s = IDLE_S;
        end else begin
          state_next_s = REQ_S;
        end
      end
      default: state_next_s = IDLE_S;
    endcase
  end

  // Prefetch FSM outputs; underrun set takes priority over clear.
  always_comb begin
    line_req_next_s     = (state_next_s == REQ_S);
    line_req_num_next_s = line_req_num_r;
    underrun_next_s     = underrun_r;
    if ((state_r == IDLE_S) && issue_s) begin
      line_req_num_next_s = next_line_s;
    end else begin
      line_req_num_next_s = line_req_num_r;
    end
    if (miss_s) begin
      underrun_next_s = 1'b1;
    end else if (underrun_clr) begin
      underrun_next_s = 1'b0;
    end else begin
      underrun_next_s = underrun_r;
    end
  end

  // Timing counters and decoded sync/blank outputs.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      h_r           <= H_VIS_C;
      v_r           <= V_LAST_C;
      hsync_r       <= ~SYNC_ACTIVE;
      vsync_r       <= ~SYNC_ACTIVE;
      video_on_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      h_r           <= h_next_s;
      v_r           <= v_next_s;
      hsync_r       <= hsync_next_s;
      vsync_r       <= vsync_next_s;
      video_on_r    <= video_on_next_s;
      frame_start_r <= frame_start_next_s;
    end
  end

  // Prefetch FSM state register.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE_S;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered prefetch request and underrun outputs.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      line_req_r     <= 1'b0;
      line_req_num_r <= 16'd0;
      underrun_r     <= 1'b0;
    end else begin
      line_req_r     <= line_req_next_s;
      line_req_num_r <= line_req_num_next_s;
      underrun_r     <= underrun_next_s;
    end
  end

  assign H_count_value = h_r;
  assign V_count_value = v_r;
  assign hsync         = hsync_r;
  assign vsync         = vsync_r;
  assign video_on      = video_on_r;
  assign frame_start   = frame_start_r;
  assign line_req      = line_req_r;
  assign line_req_num  = line_req_num_r;
  assign underrun      = underrun_r;

endmodule

// File: tb/tb_vga_timing_scheduler.sv
// Directed bench for vga_timing_scheduler; vertical timing is shortened so
// whole frames fit in a short run (13 lines: 6 visible, vsync on lines 8..9).
module tb_vga_timing_scheduler;

  localparam int VV = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VV + VF + VS + VB;
  localparam int HT = 800;
  localparam int FRAME = HT * VT;

  logic        clk_25MHz;
  logic        reset_n;
  logic        enable;
  logic [15:0] H_count_value;
  logic [15:0] V_count_value;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_start;
  logic        line_req;
  logic [15:0] line_req_num;
  logic        line_ack;
  logic        underrun;
  logic        underrun_clr;

  int passed = 0;
  int total  = 0;

  vga_timing_scheduler #(
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk_25MHz    (clk_25MHz),
    .reset_n      (reset_n),
    .enable       (enable),
    .H_count_value(H_count_value),
    .V_count_value(V_count_value),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_on     (video_on),
    .frame_start  (frame_start),
    .line_req     (line_req),
    .line_req_num (line_req_num),
    .line_ack     (line_ack),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  initial clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!((int'(H_count_value) == h) && (int'(V_count_value) == v)) && (n < 20000)) begin
      step();
      n++;
    end
    chk("run_to_pos", {H_count_value, V_count_value}, {16'(h), 16'(v)});
  endtask

  initial begin
    int hs_low, vs_low, fs_cnt, fs_first, fs_second, req_rise;
    int first_hs_h, first_vs_v, first_vs_h, held, exp_num, gap_req;
    logic prev_req;

    reset_n = 1'b0; enable = 1'b0; line_ack = 1'b0; underrun_clr = 1'b0;
    step(); step();
    chk("rst_h", H_count_value, 32'd640);
    chk("rst_v", V_count_value, 32'(VT - 1));
    chk("rst_hsync", hsync, 32'd1);
    chk("rst_vsync", vsync, 32'd1);
    chk("rst_video_on", video_on, 32'd0);
    chk("rst_frame_start", frame_start, 32'd0);
    chk("rst_line_req", line_req, 32'd0);
    chk("rst_line_req_num", line_req_num, 32'd0);
    chk("rst_underrun", underrun, 32'd0);

    // first request for line 0 issued on the first advancing edge
    reset_n = 1'b1; enable = 1'b1; line_ack = 1'b1;
    step();
    chk("c1_h", H_count_value, 32'd641);
    chk("c1_v", V_count_value, 32'(VT - 1));
    chk("c1_line_req", line_req, 32'd1);
    chk("c1_num", line_req_num, 32'd0);
    step();
    chk("c2_line_req", line_req, 32'd0);
    for (int i = 0; i < 158; i++) step();
    chk("e160_h", H_count_value, 32'd0);
    chk("e160_v", V_count_value, 32'd0);
    chk("e160_frame_start", frame_start, 32'd1);
    chk("e160_video_on", video_on, 32'd1);
    step();
    chk("e161_frame_start", frame_start, 32'd0);

    // two full frames, free-running with immediate acks
    hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = -1; fs_second = -1; req_rise = 0;
    first_hs_h = -1; first_vs_v = -1; first_vs_h = -1;
    prev_req = line_req;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (hsync == 1'b0) begin
        hs_low++;
        if (first_hs_h < 0) first_hs_h = int'(H_count_value);
      end
      if (vsync == 1'b0) begin
        vs_low++;
        if (first_vs_v < 0) begin
          first_vs_v = int'(V_count_value);
          first_vs_h = int'(H_count_value);
        end
      end
      if (frame_start == 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        else fs_second = i;
      end
      if (line_req && !prev_req) req_rise++;
      prev_req = line_req;
    end
    chk("ff_hsync_low_cycles", hs_low, 32'(2 * VT * 96));
    chk("ff_hsync_first_h", first_hs_h, 32'd656);
    chk("ff_vsync_low_cycles", vs_low, 32'(2 * VS * HT));
    chk("ff_vsync_first_v", first_vs_v, 32'(VV + VF));
    chk("ff_vsync_first_h", first_vs_h, 32'd0);
    chk("ff_frame_start_count", fs_cnt, 32'd2);
    chk("ff_frame_period", fs_second - fs_first, 32'(FRAME));
    chk("ff_req_count", req_rise, 32'(2 * VV));

    // one frame, each request acknowledged three cycles after it appears
    line_ack = 1'b0; held = 0; exp_num = 1; req_rise = 0; gap_req = 0;
    prev_req = line_req;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (line_req && !prev_req) begin
        req_rise++;
        chk("late_req_num", line_req_num, 32'(exp_num));
        exp_num = (exp_num + 1) % VV;
      end
      if (line_req && (int'(V_count_value) >= VV - 1) && (int'(V_count_value) <= VT - 2))
        gap_req++;
      prev_req = line_req;
      if (line_req) begin
        held++;
        if (held == 3) line_ack = 1'b1;
      end else begin
        held = 0;
        line_ack = 1'b0;
      end
    end
    chk("late_req_count", req_rise, 32'(VV));
    chk("late_req_in_gap", gap_req, 32'd0);
    chk("late_underrun", underrun, 32'd0);

    // request for line 5 never acknowledged
    line_ack = 1'b1;
    run_to(0, 4);
    line_ack = 1'b0;
    run_to(641, 4);
    chk("miss_req", line_req, 32'd1);
    chk("miss_num", line_req_num, 32'd5);
    run_to(799, 4);
    chk("miss_pre_req", line_req, 32'd1);
    chk("miss_pre_underrun", underrun, 32'd0);
    step();
    chk("miss_edge_v", V_count_value, 32'd5);
    chk("miss_edge_req", line_req, 32'd0);
    chk("miss_edge_underrun", underrun, 32'd1);
    line_ack = 1'b1;
    run_to(641, VT - 1);
    chk("after_miss_req", line_req, 32'd1);
    chk("after_miss_num", line_req_num, 32'd0);
    chk("after_miss_sticky", underrun, 32'd1);
    underrun_clr = 1'b1;
    step();
    chk("clr_underrun", underrun, 32'd0);
    chk("clr_req_served", line_req, 32'd0);
    underrun_clr = 1'b0;

    // ack exactly on the deadline edge
    line_ack = 1'b0;
    run_to(799, 0);
    chk("dl_req", line_req, 32'd1);
    chk("dl_num", line_req_num, 32'd1);
    line_ack = 1'b1;
    step();
    chk("dl_ack_req", line_req, 32'd0);
    chk("dl_ack_underrun", underrun, 32'd0);
    line_ack = 1'b0;
    run_to(799, 1);
    chk("dl2_req", line_req, 32'd1);
    chk("dl2_num", line_req_num, 32'd2);
    underrun_clr = 1'b1;
    step();
    chk("set_wins_underrun", underrun, 32'd1);
    chk("set_wins_req", line_req, 32'd0);
    step();
    chk("clr_after_set", underrun, 32'd0);
    underrun_clr = 1'b0;

    // freeze at H=700 with a pending request
    run_to(700, 2);
    chk("frz_req", line_req, 32'd1);
    chk("frz_num", line_req_num, 32'd3);
    chk("frz_hsync", hsync, 32'd0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("frz5_h", H_count_value, 32'd700);
    chk("frz5_req", line_req, 32'd1);
    line_ack = 1'b1;
    step();
    chk("frz_ack_req", line_req, 32'd0);
    chk("frz_ack_h", H_count_value, 32'd700);
    line_ack = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("frz10_h", H_count_value, 32'd700);
    chk("frz10_v", V_count_value, 32'd2);
    chk("frz10_hsync", hsync, 32'd0);
    chk("frz10_vsync", vsync, 32'd1);
    chk("frz10_frame_start", frame_start, 32'd0);
    enable = 1'b1;
    step();
    chk("unfrz_h", H_count_value, 32'd701);

    // async reset while a request is pending and underrun is set
    run_to(641, 3);
    chk("pre_rst_num", line_req_num, 32'd4);
    run_to(641, 4);
    chk("pre_rst_req", line_req, 32'd1);
    chk("pre_rst_num2", line_req_num, 32'd5);
    chk("pre_rst_underrun", underrun, 32'd1);
    #5 reset_n = 1'b0;
    #1;
    chk("arst_h", H_count_value, 32'd640);
    chk("arst_v", V_count_value, 32'(VT - 1));
    chk("arst_req", line_req, 32'd0);
    chk("arst_num", line_req_num, 32'd0);
    chk("arst_underrun", underrun, 32'd0);
    chk("arst_hsync", hsync, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_scheduler.md
Name: vga_timing_scheduler

Overview:
Top-level VGA timing controller for the 25 MHz pixel domain. Sequences the horizontal and vertical counters and derives hsync, vsync, video_on and frame_start. Schedules one line-prefetch request per visible line toward the frame-buffer reader during horizontal blanking, and flags a sticky underrun when the reader misses its deadline.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BACK, 48, horizontal back porch (H_TOTAL = 800)
V_VISIBLE, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync width
V_BACK, 33, vertical back porch (V_TOTAL = 525)
SYNC_ACTIVE, 0, asserted level of hsync/vsync

Ports:
clk_25MHz  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = advance timing; 0 = freeze
H_count_value  output  16  current pixel column, 0..H_TOTAL-1
V_count_value  output  16  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
video_on  output  1  1 when H<H_VISIBLE and V<V_VISIBLE
frame_start  output  1  single-cycle pulse at (H,V)=(0,0)
line_req  output  1  prefetch request, held until acknowledged
line_req_num  output  16  line index being requested
line_ack  input  1  reader has the requested line buffered
underrun  output  1  sticky deadline-miss flag
underrun_clr  input  1  clears underrun

Behaviour:
- One clock (clk_25MHz). Reset is asynchronous and active-low (reset_n). All outputs are registered.
- Reset values:
  - H_count_value = H_VISIBLE, V_count_value = V_TOTAL-1.
  - hsync = vsync = !SYNC_ACTIVE.
  - video_on = 0, frame_start = 0, line_req = 0, line_req_num = 0, underrun = 0.
  - FSM in IDLE.
- Counting (enable=1):
  - H increments each cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, V increments and wraps V_TOTAL-1 -> 0.
- Decode outputs are aligned with the counter values shown in the same cycle; they are computed from next-state, so there is zero lag.
  - hsync = SYNC_ACTIVE iff H in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751).
  - vsync = SYNC_ACTIVE iff V in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491).
  - frame_start = 1 iff (H,V) = (0,0).
- enable=0:
  - Counters and all decode outputs hold; no frame_start pulse is generated.
  - The handshake still completes: line_ack is honoured while frozen.
  - Deadline checks occur only on advancing edges.
- Prefetch FSM, states IDLE and REQ:
  - IDLE->REQ on an advancing edge where the current H = H_VISIBLE and the next line is visible.
  - Next line = V+1 if V+1 < V_VISIBLE; 0 if V = V_TOTAL-1; otherwise none.
  - On entering REQ: line_req = 1 and line_req_num = next line. Both hold stable until the request leaves REQ.
  - REQ->IDLE on any edge with line_ack = 1; line_req drops on that edge.
  - Deadline: an advancing edge that moves H to 0 while in REQ with line_ack = 0 sets underrun, drops line_req, and returns to IDLE. The request is aborted, not retried.
  - line_ack = 1 on the deadline edge counts as served; no underrun.
  - line_ack while IDLE is ignored.
- underrun:
  - Set by a deadline miss; cleared by underrun_clr = 1.
  - Simultaneous set and clear: set wins.
- Requests per frame: exactly V_VISIBLE, with line_req_num covering 0..V_VISIBLE-1 in order.
  - The request for line 0 is issued during line V_TOTAL-1.
  - No request is issued during lines V_VISIBLE-1..V_TOTAL-2.
- Reset asserted mid-operation: all state returns to reset values immediately, line_req drops asynchronously, and underrun is cleared.

Test Plan:
- Reset release, enable=1, line_ack tied 1 -> cycle 1: H=641, V=524, line_req=1, num=0. Cycle 2: line_req=0. Edge 160 reaches (0,0) with frame_start=1 for exactly 1 cycle and video_on=1.
- Free-run 2 full frames -> hsync low for exactly 96 cycles per line starting at H=656. vsync low for lines 490..491 only (1600 cycles). frame_start period = 420000 cycles.
- Acknowledge each request 3 cycles late -> 480 requests per frame with num 0..479 in order. line_req never asserted on V=479..523. underrun stays 0.
- Never acknowledge line 5 (request on V=4) -> line_req drops on the edge to (0,5) and underrun=1. Next request num=6 is issued normally. underrun stays 1 until underrun_clr pulses.
- Acknowledge on exactly the edge to H=0 -> no underrun. Same edge with underrun_clr=1 while a miss occurs -> underrun=1.
- Drop enable for 10 cycles at H=700 -> counters and syncs hold, and a pending line_ack during the freeze clears line_req. Assert reset_n=0 mid-line while line_req=1 -> outputs return immediately to H=640, V=524, line_req=0, underrun=0.
